mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width of all ports.
REQ-003 The block SHALL have port clk_i, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1, meaning reset, synchronous, active-low.
REQ-005 The block SHALL have the fetch ports:
- if_req_i, input, 1: fetch request.
- if_addr_i, input, ADDR_W: fetch address.
- if_rdata_o, output, DATA_W: fetch read data.
- if_ack_o, output, 1: fetch complete.
REQ-006 The block SHALL have the data ports:
- dm_req_i, input, 1: data request.
- dm_we_i, input, 1: 1 for store, 0 for load.
- dm_addr_i, input, ADDR_W: data address.
- dm_wdata_i, input, DATA_W: store data.
- dm_rdata_o, output, DATA_W: load data.
- dm_ack_o, output, 1: data complete.
REQ-007 The block SHALL have the backing-memory ports:
- mem_req_o, output, 1.
- mem_we_o, output, 1.
- mem_addr_o, output, ADDR_W.
- mem_wdata_o, output, DATA_W.
- mem_rdata_i, input, DATA_W.
- mem_ack_i, input, 1.
REQ-008 The block SHALL have port stall_o, output, 1, meaning pipeline freeze request.

Function
REQ-009 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-010 In IDLE with any request, the block SHALL latch the winner's address, we and wdata into mem_addr_o, mem_we_o and mem_wdata_o, set mem_req_o=1 and enter BUSY at the next edge.
- For a fetch, mem_we_o=0 and mem_wdata_o=0.
REQ-011 In IDLE with no request, the block SHALL stay in IDLE with mem_req_o=0.
REQ-012 When both requests are high in IDLE, the winner SHALL be chosen per REQ-026/REQ-027.
REQ-013 In BUSY, mem_req_o and the latched fields SHALL stay constant until mem_ack_i=1 is sampled.
REQ-014 mem_ack_i SHALL be ignored outside BUSY.
REQ-015 When mem_ack_i=1 is sampled in BUSY, the block SHALL, at the next edge:
- clear mem_req_o;
- register mem_rdata_i into the granted port's rdata_o (loads and fetches only; a store leaves dm_rdata_o unchanged);
- enter RESP.
REQ-016 In RESP, the granted port's ack_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-017 Requests SHALL NOT be sampled in RESP.
REQ-018 A request still high in the IDLE cycle after RESP SHALL be treated as a new transaction.
REQ-019 if_rdata_o and dm_rdata_o SHALL hold their last value until overwritten by a later read to the same port.
REQ-020 Latency: with the request sampled at edge 0 and mem_ack_i first high in cycle k≥1 after mem_req_o rises, ack_o SHALL be high in cycle k+1; the minimum is a 2-cycle request-to-ack.
REQ-021 A request deasserted before its ack SHALL NOT abort the transaction; the ack SHALL still pulse.
REQ-022 The losing request SHALL wait untouched and be served from the next IDLE.
REQ-023 stall_o SHALL equal (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinationally.

Reset
REQ-024 On a rising edge with rst_i=0, the block SHALL:
- enter IDLE;
- set mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0;
- set if_ack_o=0, dm_ack_o=0, if_rdata_o=0, dm_rdata_o=0;
- set last_grant to fetch.
REQ-025 Reset during BUSY or RESP SHALL abandon the transaction with no ack pulse; the mem_ack_i of that transaction SHALL be ignored.

Configuration
REQ-026 With macro MEM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL go to the port not equal to last_grant.
- last_grant SHALL update on every grant.
- After reset, data wins the first tie.
REQ-027 With MEM_ARB_RR_EN undefined, data SHALL always win a tie and last_grant SHALL NOT exist.

Verification
REQ-028 Reset, then a single fetch at 0x40 with mem_ack_i one cycle after mem_req_o and mem_rdata_i=0x8C220004 -> mem_req_o high for 2 cycles; if_ack_o high in cycle 3 with if_rdata_o=0x8C220004; stall_o low after the ack.
REQ-029 Store to addr 0x10 with wdata 0xDEADBEEF and mem_ack_i delayed 4 cycles -> mem_we_o=1 and fields stable for all 5 BUSY cycles; dm_ack_o pulses once; dm_rdata_o unchanged; stall_o high until the ack.
REQ-030 if_req_i and dm_req_i rise together and are held -> data served first, fetch second. Run 4 more paired rounds: without MEM_ARB_RR_EN, grants are D,I,D,I..., each pair re-arbitrated with data first; with MEM_ARB_RR_EN, grants alternate across ties.
REQ-031 Requester keeps dm_req_i high through RESP -> exactly one new transaction starts from IDLE, with no duplicate in RESP.
REQ-032 rst_i=0 during BUSY of a load, then mem_ack_i=1 the cycle after reset -> no dm_ack_o; mem_req_o=0; FSM in IDLE.
REQ-033 Fetch request dropped during BUSY -> if_ack_o still pulses once; no new fetch issued.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port, backing-memory
// port and the pipeline stall flag. The slave modport is the arbiter's view;
// the master modport is the view of the CPU and memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch port
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  // Data port
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;
  // Backing memory
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  // Pipeline freeze
  logic              stall_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_ack_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_ack_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i,
    output stall_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_ack_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_ack_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i,
    input  stall_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one backing-memory port between an instruction
// fetch port and a data load/store port. One transaction at a time, walking
// IDLE -> BUSY -> RESP. Reset is synchronous and active-low.
// Optional feature: define MEM_ARB_RR_EN to alternate ties between the two
// ports (round robin); otherwise the data port always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            r_state, w_state_next;
  logic              r_mem_req, w_mem_req_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
  logic              r_grant_dm, w_grant_dm_next;
  logic              r_if_ack, w_if_ack_next;
  logic              r_dm_ack, w_dm_ack_next;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_next;
  logic [DATA_W-1:0] r_dm_rdata, w_dm_rdata_next;
  logic              w_pick_dm;

`ifdef MEM_ARB_RR_EN
  // 1 when the most recent grant went to the data port; reset means fetch
  logic              r_last_dm, w_last_dm_next;

  // Data wins when it asks alone, or on a tie when fetch was granted last
  assign w_pick_dm = bus.dm_req_i & (~bus.if_req_i | ~r_last_dm);
`else
  // Data wins whenever it asks
  assign w_pick_dm = bus.dm_req_i;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and next-datapath decode
  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = r_mem_req;
    w_mem_we_next    = r_mem_we;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_grant_dm_next  = r_grant_dm;
    w_if_ack_next    = 1'b0;
    w_dm_ack_next    = 1'b0;
    w_if_rdata_next  = r_if_rdata;
    w_dm_rdata_next  = r_dm_rdata;
`ifdef MEM_ARB_RR_EN
    w_last_dm_next   = r_last_dm;
`endif
    unique case (r_state)
      IDLE: begin
        if (bus.if_req_i | bus.dm_req_i) begin
          w_state_next     = BUSY;
          w_mem_req_next   = 1'b1;
          w_grant_dm_next  = w_pick_dm;
          w_mem_we_next    = w_pick_dm & bus.dm_we_i;
          w_mem_addr_next  = w_pick_dm ? bus.dm_addr_i : bus.if_addr_i;
          w_mem_wdata_next = w_pick_dm ? bus.dm_wdata_i : '0;
`ifdef MEM_ARB_RR_EN
          w_last_dm_next   = w_pick_dm;
`endif
        end
      end
      BUSY: begin
        // Request fields stay frozen until memory acknowledges
        if (bus.mem_ack_i) begin
          w_state_next   = RESP;
          w_mem_req_next = 1'b0;
          if (r_grant_dm) begin
            w_dm_ack_next = 1'b1;
            if (!r_mem_we) w_dm_rdata_next = bus.mem_rdata_i;
          end else begin
            w_if_ack_next   = 1'b1;
            w_if_rdata_next = bus.mem_rdata_i;
          end
        end
      end
      RESP: begin
        // Ack is visible this cycle; requests are not looked at here
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath registers; reset drops any in-flight transaction silently
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_grant_dm  <= 1'b0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_dm   <= 1'b0;
`endif
    end else begin
      r_mem_req   <= w_mem_req_next;
      r_mem_we    <= w_mem_we_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_grant_dm  <= w_grant_dm_next;
      r_if_ack    <= w_if_ack_next;
      r_dm_ack    <= w_dm_ack_next;
      r_if_rdata  <= w_if_rdata_next;
      r_dm_rdata  <= w_dm_rdata_next;
`ifdef MEM_ARB_RR_EN
      r_last_dm   <= w_last_dm_next;
`endif
    end
  end

  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.if_ack_o    = r_if_ack;
  assign bus.dm_ack_o    = r_dm_ack;
  assign bus.if_rdata_o  = r_if_rdata;
  assign bus.dm_rdata_o  = r_dm_rdata;

  // Freeze the pipeline while a port is asking and has not been answered
  assign bus.stall_o = (bus.if_req_i & ~r_if_ack) | (bus.dm_req_i & ~r_dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: who was granted last, and what each port's rdata should hold
  bit            m_last_dm;
  logic [DW-1:0] m_if_rd, m_dm_rd;

  typedef struct {
    bit            timeout;
    int            wait_cyc;
    int            busy;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            stable;
    bit            stall_busy;
    int            ack_busy;
    logic          if_ack_resp;
    logic          dm_ack_resp;
    logic          stall_resp;
    logic [DW-1:0] if_rd;
    logic [DW-1:0] dm_rd;
    logic          idle_ack;
    logic          idle_req;
  } obs_t;

  function automatic bit model_pick_dm(bit ireq, bit dreq);
    if (!ireq) return 1'b1;
    if (!dreq) return 1'b0;
`ifdef MEM_ARB_RR_EN
    return !m_last_dm;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive_idle();
    step(); step();
    rst_n = 1;
    m_last_dm = 0; m_if_rd = '0; m_dm_rd = '0;
  endtask

  // Plays the memory side of one transaction: waits for mem_req_o, acks in busy
  // cycle d+1 with rd, and records what the arbiter showed. Returns in the IDLE
  // cycle after RESP. drop clears both requests in the first busy cycle; junk
  // drives a spurious mem_ack_i during RESP.
  task automatic serve_one(input int d, input logic [DW-1:0] rd, input bit drop,
                           input bit junk, output obs_t o);
    int n;
    o = '{default: '0};
    o.stable = 1; o.stall_busy = 1;
    n = 0;
    do begin step(); n++; end while (!bus.mem_req_o && n < 12);
    o.wait_cyc = n;
    if (!bus.mem_req_o) begin o.timeout = 1; return; end
    o.we = bus.mem_we_o; o.addr = bus.mem_addr_o; o.wdata = bus.mem_wdata_o;
    if (drop) begin bus.if_req_i = 0; bus.dm_req_i = 0; end
    o.busy = 1;
    while (1) begin
      #1;
      if (bus.stall_o !== 1'b1) o.stall_busy = 0;
      if (bus.if_ack_o || bus.dm_ack_o) o.ack_busy++;
      bus.mem_ack_i   = (o.busy == d + 1);
      bus.mem_rdata_i = (o.busy == d + 1) ? rd : $urandom;
      step();
      bus.mem_ack_i = 0;
      if (!bus.mem_req_o) break;
      o.busy++;
      if (bus.mem_we_o !== o.we || bus.mem_addr_o !== o.addr || bus.mem_wdata_o !== o.wdata)
        o.stable = 0;
      if (o.busy > 20) begin o.timeout = 1; return; end
    end
    o.if_ack_resp = bus.if_ack_o; o.dm_ack_resp = bus.dm_ack_o;
    o.if_rd = bus.if_rdata_o; o.dm_rd = bus.dm_rdata_o;
    #1 o.stall_resp = bus.stall_o;
    bus.mem_ack_i = junk; bus.mem_rdata_i = $urandom;
    step();
    bus.mem_ack_i = 0;
    o.idle_ack = bus.if_ack_o | bus.dm_ack_o;
    o.idle_req = bus.mem_req_o;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.if_req_i = 1; bus.if_addr_i = $urandom; bus.dm_req_i = 1; bus.dm_we_i = 1;
    bus.dm_addr_i = $urandom; bus.dm_wdata_i = $urandom; bus.mem_ack_i = 1; bus.mem_rdata_i = $urandom;
    step(); step();
    drive_idle();
    #1;
    n_total++; if (bus.mem_req_o !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", bus.mem_req_o); else n_pass++;
    n_total++; if (bus.mem_we_o !== 1'b0) $display("FAIL rst_mem_we: got %b want 0", bus.mem_we_o); else n_pass++;
    n_total++; if (bus.mem_addr_o !== '0) $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr_o); else n_pass++;
    n_total++; if (bus.mem_wdata_o !== '0) $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata_o); else n_pass++;
    n_total++; if ({bus.if_ack_o, bus.dm_ack_o} !== 2'b00) $display("FAIL rst_acks: got %b%b want 00", bus.if_ack_o, bus.dm_ack_o); else n_pass++;
    n_total++; if (bus.if_rdata_o !== '0) $display("FAIL rst_if_rdata: got %h want 0", bus.if_rdata_o); else n_pass++;
    n_total++; if (bus.dm_rdata_o !== '0) $display("FAIL rst_dm_rdata: got %h want 0", bus.dm_rdata_o); else n_pass++;
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", bus.stall_o); else n_pass++;
    rst_n = 1;
    m_last_dm = 0; m_if_rd = '0; m_dm_rd = '0;
    step();
    n_total++; if (bus.mem_req_o !== 1'b0) $display("FAIL idle_no_req: got %b want 0", bus.mem_req_o); else n_pass++;
  endtask

  task automatic test_single_fetch();
    obs_t o;
    do_reset();
    bus.if_req_i = 1; bus.if_addr_i = 32'h40;
    serve_one(1, 32'h8C220004, 0, 0, o);
    m_if_rd = 32'h8C220004;
    $display("txn fetch addr=%h busy=%0d ack_cycle=%0d rdata=%h", o.addr, o.busy, o.wait_cyc + o.busy, o.if_rd);
    n_total++; if (o.timeout !== 1'b0) $display("FAIL fetch_timeout: got %b want 0", o.timeout); else n_pass++;
    n_total++; if (o.busy != 2) $display("FAIL fetch_req_cycles: got %0d want 2", o.busy); else n_pass++;
    n_total++; if (o.wait_cyc + o.busy != 3) $display("FAIL fetch_ack_cycle: got %0d want 3", o.wait_cyc + o.busy); else n_pass++;
    n_total++; if ({o.we, o.addr, o.wdata} !== {1'b0, 32'h40, 32'h0}) $display("FAIL fetch_fields: got we=%b addr=%h wd=%h want 0/40/0", o.we, o.addr, o.wdata); else n_pass++;
    n_total++; if ({o.if_ack_resp, o.dm_ack_resp} !== 2'b10) $display("FAIL fetch_ack: got %b%b want 10", o.if_ack_resp, o.dm_ack_resp); else n_pass++;
    n_total++; if (o.if_rd !== m_if_rd) $display("FAIL fetch_rdata: got %h want %h", o.if_rd, m_if_rd); else n_pass++;
    n_total++; if (o.stall_resp !== 1'b0) $display("FAIL fetch_stall_resp: got %b want 0", o.stall_resp); else n_pass++;
    bus.if_req_i = 0;
    #1;
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL fetch_stall_after: got %b want 0", bus.stall_o); else n_pass++;
    n_total++; if ({o.idle_ack, o.idle_req} !== 2'b00) $display("FAIL fetch_idle: got ack=%b req=%b want 0 0", o.idle_ack, o.idle_req); else n_pass++;
  endtask

  task automatic test_store();
    obs_t o;
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h14;
    serve_one(0, 32'h12345678, 0, 0, o);
    m_dm_rd = 32'h12345678;
    $display("txn load addr=%h busy=%0d rdata=%h", o.addr, o.busy, o.dm_rd);
    n_total++; if (o.busy != 1) $display("FAIL load_min_busy: got %0d want 1", o.busy); else n_pass++;
    n_total++; if (o.dm_rd !== m_dm_rd) $display("FAIL load_rdata: got %h want %h", o.dm_rd, m_dm_rd); else n_pass++;
    bus.dm_we_i = 1; bus.dm_addr_i = 32'h10; bus.dm_wdata_i = 32'hDEADBEEF;
    serve_one(4, 32'hCAFEF00D, 0, 0, o);
    $display("txn store addr=%h wdata=%h busy=%0d", o.addr, o.wdata, o.busy);
    n_total++; if (o.busy != 5) $display("FAIL store_busy: got %0d want 5", o.busy); else n_pass++;
    n_total++; if ({o.we, o.addr, o.wdata} !== {1'b1, 32'h10, 32'hDEADBEEF}) $display("FAIL store_fields: got we=%b addr=%h wd=%h", o.we, o.addr, o.wdata); else n_pass++;
    n_total++; if (o.stable !== 1'b1) $display("FAIL store_stable: got %b want 1", o.stable); else n_pass++;
    n_total++; if (o.stall_busy !== 1'b1) $display("FAIL store_stall_busy: got %b want 1", o.stall_busy); else n_pass++;
    n_total++; if ({o.ack_busy != 0, o.dm_ack_resp, o.idle_ack} !== 3'b010) $display("FAIL store_ack_pulse: got early=%0d resp=%b late=%b", o.ack_busy, o.dm_ack_resp, o.idle_ack); else n_pass++;
    n_total++; if (o.dm_rd !== m_dm_rd) $display("FAIL store_rdata_kept: got %h want %h", o.dm_rd, m_dm_rd); else n_pass++;
    n_total++; if (o.stall_resp !== 1'b0) $display("FAIL store_stall_resp: got %b want 0", o.stall_resp); else n_pass++;
    drive_idle();
  endtask

  task automatic test_tie();
    obs_t o;
    bit pdm;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      bus.if_req_i = 1; bus.if_addr_i = 32'h100 + r * 8;
      bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h200 + r * 8;
      for (int t = 0; t < 2; t++) begin
        pdm = model_pick_dm(bus.if_req_i, bus.dm_req_i);
        m_last_dm = pdm;
        serve_one($urandom_range(0, 2), $urandom, 0, 0, o);
        $display("txn tie round=%0d slot=%0d port=%s addr=%h", r, t, o.dm_ack_resp ? "D" : "I", o.addr);
        n_total++; if (o.addr !== (pdm ? bus.dm_addr_i : bus.if_addr_i)) $display("FAIL tie_addr r%0d t%0d: got %h want %h", r, t, o.addr, pdm ? bus.dm_addr_i : bus.if_addr_i); else n_pass++;
        n_total++; if ({o.if_ack_resp, o.dm_ack_resp} !== {!pdm, pdm}) $display("FAIL tie_port r%0d t%0d: got %b%b want %b%b", r, t, o.if_ack_resp, o.dm_ack_resp, !pdm, pdm); else n_pass++;
        if (pdm) begin m_dm_rd = o.dm_rd; bus.dm_req_i = 0; end
        else begin m_if_rd = o.if_rd; bus.if_req_i = 0; end
      end
    end
    drive_idle();
  endtask

  task automatic test_hold_resp();
    obs_t o1, o2;
    bit saw;
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h30;
    serve_one(1, 32'hA5A5_0001, 0, 0, o1);
    serve_one(0, 32'hA5A5_0002, 0, 0, o2);
    bus.dm_req_i = 0;
    m_dm_rd = 32'hA5A5_0002;
    $display("txn hold first_ack=%b dup=%b second_wait=%0d", o1.dm_ack_resp, o1.idle_req, o2.wait_cyc);
    n_total++; if (o1.dm_ack_resp !== 1'b1) $display("FAIL hold_first_ack: got %b want 1", o1.dm_ack_resp); else n_pass++;
    n_total++; if (o1.idle_req !== 1'b0) $display("FAIL hold_no_dup_in_resp: got %b want 0", o1.idle_req); else n_pass++;
    n_total++; if (o2.wait_cyc != 1) $display("FAIL hold_new_txn_start: got %0d want 1", o2.wait_cyc); else n_pass++;
    n_total++; if (o2.dm_rd !== m_dm_rd) $display("FAIL hold_second_rdata: got %h want %h", o2.dm_rd, m_dm_rd); else n_pass++;
    saw = 0;
    for (int i = 0; i < 4; i++) begin step(); if (bus.mem_req_o) saw = 1; end
    n_total++; if (saw !== 1'b0) $display("FAIL hold_no_extra_txn: got %b want 0", saw); else n_pass++;
  endtask

  task automatic test_reset_busy();
    obs_t o;
    int n;
    bit bad_ack;
    do_reset();
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h20;
    n = 0;
    do begin step(); n++; end while (!bus.mem_req_o && n < 8);
    n_total++; if (bus.mem_req_o !== 1'b1) $display("FAIL rstb_enter_busy: got %b want 1", bus.mem_req_o); else n_pass++;
    step();
    rst_n = 0; bus.dm_req_i = 0;
    step();
    rst_n = 1;
    m_last_dm = 0; m_if_rd = '0; m_dm_rd = '0;
    n_total++; if (bus.mem_req_o !== 1'b0) $display("FAIL rstb_mem_req: got %b want 0", bus.mem_req_o); else n_pass++;
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h5555AAAA;
    bad_ack = bus.dm_ack_o;
    step();
    bus.mem_ack_i = 0;
    bad_ack |= bus.dm_ack_o;
    step();
    bad_ack |= bus.dm_ack_o;
    n_total++; if (bad_ack !== 1'b0) $display("FAIL rstb_no_ack: got %b want 0", bad_ack); else n_pass++;
    n_total++; if ({bus.mem_req_o, bus.dm_rdata_o} !== {1'b0, m_dm_rd}) $display("FAIL rstb_idle: got req=%b rd=%h want 0/%h", bus.mem_req_o, bus.dm_rdata_o, m_dm_rd); else n_pass++;
    bus.if_req_i = 1; bus.if_addr_i = 32'h44;
    serve_one(0, 32'h0BADCAFE, 0, 0, o);
    bus.if_req_i = 0;
    m_if_rd = 32'h0BADCAFE;
    $display("txn after_reset fetch wait=%0d ack=%b", o.wait_cyc, o.if_ack_resp);
    n_total++; if ({o.wait_cyc == 1, o.if_ack_resp} !== 2'b11) $display("FAIL rstb_fsm_idle: got wait=%0d ack=%b want 1 1", o.wait_cyc, o.if_ack_resp); else n_pass++;
  endtask

  task automatic test_drop_fetch();
    obs_t o;
    bit saw;
    bus.if_req_i = 1; bus.if_addr_i = 32'h80;
    serve_one(2, 32'h13579BDF, 1, 1, o);
    m_if_rd = 32'h13579BDF;
    $display("txn dropped_fetch busy=%0d ack=%b rdata=%h", o.busy, o.if_ack_resp, o.if_rd);
    n_total++; if ({o.ack_busy != 0, o.if_ack_resp, o.idle_ack} !== 3'b010) $display("FAIL drop_ack_pulse: got early=%0d resp=%b late=%b", o.ack_busy, o.if_ack_resp, o.idle_ack); else n_pass++;
    n_total++; if (o.if_rd !== m_if_rd) $display("FAIL drop_rdata: got %h want %h", o.if_rd, m_if_rd); else n_pass++;
    saw = o.idle_req;
    for (int i = 0; i < 3; i++) begin step(); if (bus.mem_req_o) saw = 1; end
    n_total++; if (saw !== 1'b0) $display("FAIL drop_no_new_fetch: got %b want 0", saw); else n_pass++;
    n_total++; if (bus.stall_o !== 1'b0) $display("FAIL drop_stall: got %b want 0", bus.stall_o); else n_pass++;
  endtask

  task automatic test_random();
    obs_t o;
    bit ireq, dreq, we, pdm, loser;
    int d;
    logic [DW-1:0] rd;
    for (int it = 0; it < 30; it++) begin
      ireq = 1'($urandom_range(0, 1));
      dreq = ireq ? 1'($urandom_range(0, 1)) : 1'b1;
      we = 1'($urandom_range(0, 1));
      bus.if_req_i = ireq; bus.if_addr_i = $urandom;
      bus.dm_req_i = dreq; bus.dm_we_i = we; bus.dm_addr_i = $urandom; bus.dm_wdata_i = $urandom;
      for (int t = 0; t < 2; t++) begin
        if (!ireq && !dreq) break;
        pdm = model_pick_dm(ireq, dreq);
        loser = pdm ? ireq : dreq;
        m_last_dm = pdm;
        d = $urandom_range(0, 3);
        rd = $urandom;
        serve_one(d, rd, 0, 1'($urandom_range(0, 1)), o);
        if (pdm) begin if (!we) m_dm_rd = rd; end
        else m_if_rd = rd;
        $display("txn rnd it=%0d port=%s we=%b addr=%h busy=%0d last_dm=%b", it, pdm ? "D" : "I", o.we, o.addr, o.busy, m_last_dm);
        n_total++; if ({o.timeout, o.wait_cyc == 1, o.busy == d + 1} !== 3'b011) $display("FAIL rnd_timing it%0d: got to=%b wait=%0d busy=%0d want busy %0d", it, o.timeout, o.wait_cyc, o.busy, d + 1); else n_pass++;
        n_total++; if (o.we !== (pdm & we)) $display("FAIL rnd_we it%0d: got %b want %b", it, o.we, pdm & we); else n_pass++;
        n_total++; if (o.addr !== (pdm ? bus.dm_addr_i : bus.if_addr_i)) $display("FAIL rnd_addr it%0d: got %h want %h", it, o.addr, pdm ? bus.dm_addr_i : bus.if_addr_i); else n_pass++;
        n_total++; if (o.wdata !== (pdm ? bus.dm_wdata_i : '0)) $display("FAIL rnd_wdata it%0d: got %h want %h", it, o.wdata, pdm ? bus.dm_wdata_i : '0); else n_pass++;
        n_total++; if ({o.stable, o.stall_busy} !== 2'b11) $display("FAIL rnd_busy_hold it%0d: got stable=%b stall=%b want 1 1", it, o.stable, o.stall_busy); else n_pass++;
        n_total++; if ({o.if_ack_resp, o.dm_ack_resp} !== {!pdm, pdm}) $display("FAIL rnd_ack_port it%0d: got %b%b want %b%b", it, o.if_ack_resp, o.dm_ack_resp, !pdm, pdm); else n_pass++;
        n_total++; if (o.if_rd !== m_if_rd) $display("FAIL rnd_if_rdata it%0d: got %h want %h", it, o.if_rd, m_if_rd); else n_pass++;
        n_total++; if (o.dm_rd !== m_dm_rd) $display("FAIL rnd_dm_rdata it%0d: got %h want %h", it, o.dm_rd, m_dm_rd); else n_pass++;
        n_total++; if (o.stall_resp !== loser) $display("FAIL rnd_stall_resp it%0d: got %b want %b", it, o.stall_resp, loser); else n_pass++;
        n_total++; if ({o.ack_busy != 0, o.idle_ack, o.idle_req} !== 3'b000) $display("FAIL rnd_single_pulse it%0d: got early=%0d late=%b req=%b", it, o.ack_busy, o.idle_ack, o.idle_req); else n_pass++;
        if (pdm) dreq = 0; else ireq = 0;
        bus.if_req_i = ireq; bus.dm_req_i = dreq;
      end
      drive_idle();
      step();
    end
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    test_reset();
    test_single_fetch();
    test_store();
    test_tie();
    test_hold_resp();
    test_reset_busy();
    test_drop_fetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit so the run always ends with a summary
  initial begin
    #200000;
    n_total++;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
